// File: rtl/ball_link_scheduler.sv
// ball_link_scheduler: snapshots the ball state and hands it to the peer board as a checksummed I2C frame with retry.
// Ports:
//   clk, reset (async, active-low)       clock and reset
//   ball_send_trigger, ball_y/vy, gravity, ball_speed   hand-off request and ball state to snapshot
//   m_ready, m_done, m_ack_err           I2C master status
//   m_start, m_addr, m_data, m_last      I2C master byte request (m_last marks the checksum byte)
//   is_transfer, go_left, xfer_fail      busy flag, delivered pulse, retries-exhausted pulse
//   slv_reg0_y0 .. slv_reg4_ballspeed    snapshot registers for the display
module ball_link_scheduler #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 250000,
    parameter int         MAX_RETRY   = 3,
    parameter int         BACKOFF_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ball_send_trigger,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [7:0] gravity,
    input  logic [7:0] ball_speed,
    input  logic       m_ready,
    input  logic       m_done,
    input  logic       m_ack_err,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       is_transfer,
    output logic       go_left,
    output logic       xfer_fail,
    output logic [7:0] slv_reg0_y0,
    output logic [7:0] slv_reg1_y1,
    output logic [7:0] slv_reg2_vy,
    output logic [7:0] slv_reg3_gravity,
    output logic [7:0] slv_reg4_ballspeed
);
    localparam int CW = $clog2((TIMEOUT_CYC > BACKOFF_CYC ? TIMEOUT_CYC : BACKOFF_CYC) + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, BACKOFF, DONE, FAIL} state_t;
    state_t          state, state_n;
    logic [2:0]      idx, idx_n;
    logic [RW-1:0]   retry, retry_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [7:0]      csum, byte_n;
    logic            pend;
    // One counter serves both the per-byte timeout (WAIT) and the retry back-off (BACKOFF).
    always_comb begin
        state_n = state;
        idx_n   = idx;
        retry_n = retry;
        cnt_n   = (cnt != '0) ? cnt - CW'(1) : cnt;
        m_start = 1'b0;
        case (state)
            IDLE:    state_n = ball_send_trigger ? LATCH : IDLE;
            LATCH: begin
                state_n = ISSUE;
                idx_n   = '0;
                retry_n = '0;
            end
            ISSUE: if (m_ready) begin
                m_start = 1'b1;
                cnt_n   = CW'(TIMEOUT_CYC - 1);
                state_n = WAIT;
            end
            WAIT: if (m_done && !m_ack_err) begin
                idx_n   = (idx == 3'd6) ? idx : idx + 3'd1;
                state_n = (idx == 3'd6) ? DONE : ISSUE;
            end else if (m_done || cnt == '0) begin
                retry_n = (retry < RW'(MAX_RETRY)) ? retry + RW'(1) : retry;
                cnt_n   = CW'(BACKOFF_CYC - 1);
                state_n = (retry < RW'(MAX_RETRY)) ? BACKOFF : FAIL;
            end
            BACKOFF: if (cnt == '0) begin
                idx_n   = '0;
                state_n = ISSUE;
            end
            DONE, FAIL: state_n = (pend || ball_send_trigger) ? LATCH : IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign byte_n = idx_n == 3'd0 ? HEADER :
                    idx_n == 3'd1 ? slv_reg0_y0 :
                    idx_n == 3'd2 ? slv_reg1_y1 :
                    idx_n == 3'd3 ? slv_reg2_vy :
                    idx_n == 3'd4 ? slv_reg3_gravity :
                    idx_n == 3'd5 ? slv_reg4_ballspeed : csum;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            idx                <= '0;
            retry              <= '0;
            cnt                <= '0;
            pend               <= 1'b0;
            csum               <= '0;
            m_addr             <= '0;
            m_data             <= '0;
            m_last             <= 1'b0;
            slv_reg0_y0        <= '0;
            slv_reg1_y1        <= '0;
            slv_reg2_vy        <= '0;
            slv_reg3_gravity   <= '0;
            slv_reg4_ballspeed <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            retry <= retry_n;
            cnt   <= cnt_n;
            // A trigger in DONE/FAIL is consumed directly by the jump to LATCH.
            pend  <= (state == DONE || state == FAIL) ? 1'b0 : pend | (ball_send_trigger && state != IDLE);
            if (state == LATCH) begin
                slv_reg0_y0        <= ball_y[7:0];
                slv_reg1_y1        <= {6'b0, ball_y[9:8]};
                slv_reg2_vy        <= ball_vy;
                slv_reg3_gravity   <= gravity;
                slv_reg4_ballspeed <= ball_speed;
                csum               <= ball_y[7:0] ^ {6'b0, ball_y[9:8]} ^ ball_vy ^ gravity ^ ball_speed;
            end
            // Byte outputs change only on ISSUE entry, so they stay stable through the matching m_done.
            if (state_n == ISSUE && state != ISSUE) begin
                m_addr <= SLAVE_ADDR;
                m_data <= byte_n;
                m_last <= (idx_n == 3'd6);
            end
        end
    end
    assign is_transfer = (state != IDLE);
    assign go_left     = (state == DONE);
    assign xfer_fail   = (state == FAIL);
endmodule

// File: tb/tb_ball_link_scheduler.sv
// tb_ball_link_scheduler: scoreboard bench for the ball hand-off frame scheduler.
module tb_ball_link_scheduler;
    localparam int TO = 100;
    typedef struct packed {logic [7:0] d; logic l;} exp_t;
    logic clk = 0, reset = 0, trig = 0;
    logic [9:0] y = '0;
    logic [7:0] vy = '0, g = '0, sp = '0;
    logic m_ready = 1, m_done = 0, m_ack_err = 0;
    logic m_start, m_last, is_transfer, go_left, xfer_fail;
    logic [6:0] m_addr;
    logic [7:0] m_data, r0, r1, r2, r3, r4;
    int checks = 0, errors = 0;
    int cyc = 0, n_start = 0, n_go = 0, n_fail = 0, go_cyc = 0, fail_cyc = 0, done_cyc = 0, nack_cyc = 0;
    int start_cycles[$];
    exp_t sb[$];
    bit silent = 0, merr = 0;
    int lat = 2, mcnt = 0, nack_at = -1;

    ball_link_scheduler #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ball_send_trigger(trig), .ball_y(y), .ball_vy(vy),
        .gravity(g), .ball_speed(sp), .m_ready(m_ready), .m_done(m_done), .m_ack_err(m_ack_err),
        .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_last(m_last),
        .is_transfer(is_transfer), .go_left(go_left), .xfer_fail(xfer_fail),
        .slv_reg0_y0(r0), .slv_reg1_y1(r1), .slv_reg2_vy(r2), .slv_reg3_gravity(r3), .slv_reg4_ballspeed(r4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (m_start) begin
            n_start++;
            start_cycles.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: m_start with data=%h, required no start", m_data);
            end else begin
                e = sb.pop_front();
                if ({m_data, m_last, m_addr} !== {e.d, e.l, 7'h42}) begin
                    errors++;
                    $display("FAIL byte: got data=%h last=%b addr=%h, required data=%h last=%b addr=42",
                             m_data, m_last, m_addr, e.d, e.l);
                end
            end
        end
        if (m_done && m_last && !m_ack_err) done_cyc = cyc;
        if (m_done && m_ack_err) nack_cyc = cyc;
        if (go_left) begin n_go++; go_cyc = cyc; end
        if (xfer_fail) begin n_fail++; fail_cyc = cyc; end
    end

    // I2C master model: answers each m_start with m_done lat+1 cycles later.
    initial forever begin
        @(negedge clk);
        if (m_start && !silent && reset) begin
            merr = (mcnt == nack_at);
            mcnt++;
            repeat (lat + 1) @(posedge clk);
            #1 m_done = 1; m_ack_err = merr;
            @(posedge clk);
            #1 m_done = 0; m_ack_err = 0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1ms, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [9:0] yy, input logic [7:0] v, input logic [7:0] gg,
                              input logic [7:0] s, input int n);
        logic [7:0] f [7];
        f[0] = 8'hA5; f[1] = yy[7:0]; f[2] = {6'b0, yy[9:8]}; f[3] = v; f[4] = gg; f[5] = s;
        f[6] = yy[7:0] ^ {6'b0, yy[9:8]} ^ v ^ gg ^ s;
        for (int i = 0; i < n; i++) sb.push_back('{f[i], i == 6});
    endtask

    task automatic send(input logic [9:0] yy, input logic [7:0] v, input logic [7:0] gg, input logic [7:0] s);
        @(posedge clk);
        #1 y = yy; vy = v; g = gg; sp = s; trig = 1;
        @(posedge clk);
        #1 trig = 0;
        @(negedge clk);
        checks++;
        if (is_transfer !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_trigger: is_transfer=%b, required 1", is_transfer);
        end
    endtask

    task automatic wait_evt(input bit want_fail, input int target, input int budget, input string name);
        int k = 0;
        while ((want_fail ? n_fail : n_go) < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if ((want_fail ? n_fail : n_go) < target) begin
            errors++;
            $display("FAIL %s_wait: event count %0d after %0d cycles, required %0d", name,
                     want_fail ? n_fail : n_go, budget, target);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_regs(input string name, input logic [39:0] want);
        checks++;
        if ({r0, r1, r2, r3, r4} !== want) begin
            errors++;
            $display("FAIL %s: regs=%h, required %h", name, {r0, r1, r2, r3, r4}, want);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({m_start, m_addr, m_data, m_last, is_transfer, go_left, xfer_fail, r0, r1, r2, r3, r4} !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h, required all 0", name,
                     {m_start, m_addr, m_data, m_last, is_transfer, go_left, xfer_fail, r0, r1, r2, r3, r4});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset_outputs");
        reset = 1;
        repeat (3) @(posedge clk);
        #1 check_int("idle_no_start", n_start, 0);
    endtask

    task automatic test_nominal();
        int go0 = n_go, f0 = n_fail;
        push_frame(10'h1F4, 8'h05, 8'h02, 8'h10, 7);
        send(10'h1F4, 8'h05, 8'h02, 8'h10);
        wait_evt(0, go0 + 1, 200, "nominal");
        repeat (5) @(posedge clk);
        #1 check_int("nominal_go", n_go, go0 + 1);
        check_int("nominal_nofail", n_fail, f0);
        check_int("nominal_sb_left", sb.size(), 0);
        check_int("nominal_go_latency", go_cyc - done_cyc, 1);
        check_regs("nominal_regs", 40'hF4_01_05_02_10);
        check_int("nominal_idle", int'(is_transfer), 0);
    endtask

    task automatic test_stall();
        int go0 = n_go, s0 = n_start;
        m_ready = 0;
        push_frame(10'h0AB, 8'h33, 8'h01, 8'h44, 7);
        send(10'h0AB, 8'h33, 8'h01, 8'h44);
        repeat (50) @(posedge clk);
        #1 check_int("stall_no_start", n_start, s0);
        check_int("stall_busy", int'(is_transfer), 1);
        m_ready = 1;
        @(negedge clk);
        check_int("stall_start_on_ready", int'(m_start), 1);
        wait_evt(0, go0 + 1, 200, "stall");
        check_int("stall_nofail", n_fail, 0);
    endtask

    task automatic test_nack();
        int go0 = n_go, f0 = n_fail, b = start_cycles.size();
        nack_at = mcnt + 3;
        push_frame(10'h2C8, 8'h7A, 8'h03, 8'h0F, 4);
        push_frame(10'h2C8, 8'h7A, 8'h03, 8'h0F, 7);
        send(10'h2C8, 8'h7A, 8'h03, 8'h0F);
        wait_evt(0, go0 + 1, 400, "nack");
        repeat (5) @(posedge clk);
        #1 nack_at = -1;
        check_int("nack_go", n_go, go0 + 1);
        check_int("nack_nofail", n_fail, f0);
        check_int("nack_sb_left", sb.size(), 0);
        check_int("nack_backoff_gap", start_cycles.size() > b + 4 ? start_cycles[b + 4] - nack_cyc : -1, 17);
    endtask

    task automatic test_back_to_back();
        int go0 = n_go;
        push_frame(10'h2A7, 8'h11, 8'h03, 8'h20, 7);
        send(10'h2A7, 8'h11, 8'h03, 8'h20);
        repeat (10) @(posedge clk);
        push_frame(10'h0C3, 8'hF0, 8'h01, 8'h7E, 7);
        send(10'h0C3, 8'hF0, 8'h01, 8'h7E);
        repeat (5) @(posedge clk);
        #1 trig = 1;
        @(posedge clk);
        #1 trig = 0;
        wait_evt(0, go0 + 2, 500, "b2b");
        repeat (40) @(posedge clk);
        #1 check_int("b2b_go", n_go, go0 + 2);
        check_int("b2b_sb_left", sb.size(), 0);
        check_regs("b2b_regs", 40'hC3_00_F0_01_7E);
        check_int("b2b_idle", int'(is_transfer), 0);
    endtask

    task automatic test_done_trigger();
        int go0 = n_go, k = 0;
        push_frame(10'h155, 8'h22, 8'h04, 8'h33, 7);
        send(10'h155, 8'h22, 8'h04, 8'h33);
        while (!go_left && k < 200) begin @(negedge clk); k++; end
        check_int("donetrig_seen_done", int'(go_left), 1);
        y = 10'h3FF; vy = 8'h80; g = 8'h08; sp = 8'h01; trig = 1;
        push_frame(10'h3FF, 8'h80, 8'h08, 8'h01, 7);
        @(posedge clk);
        #1 trig = 0;
        wait_evt(0, go0 + 2, 300, "donetrig");
        repeat (5) @(posedge clk);
        #1 check_int("donetrig_go", n_go, go0 + 2);
        check_int("donetrig_sb_left", sb.size(), 0);
        check_regs("donetrig_regs", 40'hFF_03_80_08_01);
    endtask

    task automatic test_done_at_timeout();
        int go0 = n_go, f0 = n_fail, s0 = n_start;
        lat = TO - 1;
        push_frame(10'h0F0, 8'h01, 8'h02, 8'h03, 7);
        send(10'h0F0, 8'h01, 8'h02, 8'h03);
        wait_evt(0, go0 + 1, 1500, "edge_done");
        repeat (5) @(posedge clk);
        #1 lat = 2;
        check_int("edge_done_nofail", n_fail, f0);
        check_int("edge_done_starts", n_start - s0, 7);
    endtask

    task automatic test_timeout();
        int go0 = n_go, f0 = n_fail, b = start_cycles.size();
        silent = 1;
        for (int i = 0; i < 4; i++) push_frame(10'h111, 8'h22, 8'h33, 8'h44, 1);
        send(10'h111, 8'h22, 8'h33, 8'h44);
        wait_evt(1, f0 + 1, 1000, "timeout");
        repeat (20) @(posedge clk);
        #1 silent = 0;
        check_int("timeout_fail", n_fail, f0 + 1);
        check_int("timeout_nogo", n_go, go0);
        check_int("timeout_attempts", start_cycles.size() - b, 4);
        check_int("timeout_retry_gap", start_cycles.size() > b + 1 ? start_cycles[b + 1] - start_cycles[b] : -1, TO + 17);
        check_int("timeout_fail_latency", start_cycles.size() > b + 3 ? fail_cyc - start_cycles[b + 3] : -1, TO + 1);
    endtask

    task automatic test_reset_mid();
        int go0 = n_go, f0 = n_fail, s0 = n_start, k = 0;
        push_frame(10'h1AA, 8'h55, 8'h66, 8'h77, 7);
        send(10'h1AA, 8'h55, 8'h66, 8'h77);
        while (n_start < s0 + 3 && k < 100) begin @(posedge clk); k++; end
        check_int("rstmid_reached_byte2", n_start - s0, 3);
        @(negedge clk);
        reset = 0;
        #1 check_zero("rstmid_outputs");
        sb.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1;
        s0 = n_start;
        repeat (50) @(posedge clk);
        #1 check_int("rstmid_no_start", n_start, s0);
        check_int("rstmid_no_go", n_go, go0);
        check_int("rstmid_no_fail", n_fail, f0);
        check_int("rstmid_idle", int'(is_transfer), 0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_nack();
        test_back_to_back();
        test_done_trigger();
        test_done_at_timeout();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
